// File: rtl/cpu_decoder_if.sv
// cpu_decoder_if: multiplexed CPU bus plus local register-space request/ack signals
interface cpu_decoder_if #(
   parameter int ADDR_W = 32
);
   logic [31:0]       bus_ad_i;
   logic              bus_adrcy_i;
   logic              bus_dcy_i;
   logic              tm1n_i;
   logic              tm0n_i;
   logic [31:0]       bus_ad_o;
   logic              bus_ad_oe;
   logic              bus_rdy_o;
   logic              bus_err_o;
   logic [ADDR_W-1:0] loc_addr_o;
   logic [3:0]        loc_wstrb_o;
   logic [31:0]       loc_wdata_o;
   logic              loc_wr_o;
   logic              loc_rd_o;
   logic [31:0]       loc_rdata_i;
   logic              loc_ack_i;
   logic              overrun_o;
   modport slave (
      input  bus_ad_i, bus_adrcy_i, bus_dcy_i, tm1n_i, tm0n_i, loc_rdata_i, loc_ack_i,
      output bus_ad_o, bus_ad_oe, bus_rdy_o, bus_err_o, loc_addr_o, loc_wstrb_o,
             loc_wdata_o, loc_wr_o, loc_rd_o, overrun_o
   );
   modport master (
      output bus_ad_i, bus_adrcy_i, bus_dcy_i, tm1n_i, tm0n_i, loc_rdata_i, loc_ack_i,
      input  bus_ad_o, bus_ad_oe, bus_rdy_o, bus_err_o, loc_addr_o, loc_wstrb_o,
             loc_wdata_o, loc_wr_o, loc_rd_o, overrun_o
   );
endinterface

// File: rtl/cpu_decoder.sv
// cpu_decoder: target-side decoder turning multiplexed bus cycles into local register requests
module cpu_decoder #(
   parameter int TIMEOUT = 16,
   parameter int ADDR_W  = 32
) (
   input logic         clk,
   input logic         rstn,
   cpu_decoder_if.slave bus
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);
   typedef enum logic [1:0] {IDLE, WDATA, REQ, DONE} state_t;
   state_t        state;
   logic [CW-1:0] cnt;
   logic          dec_rd;
   logic          dec_bad;
   logic [3:0]    dec_strb;
   // decode transfer mode and lane code into read / byte strobes / illegal
   always_comb begin
      dec_rd   = 1'b0;
      dec_bad  = 1'b0;
      dec_strb = 4'b0000;
      case ({bus.tm1n_i, bus.tm0n_i, bus.bus_ad_i[1:0]})
         4'b1100: dec_rd   = 1'b1;
         4'b0000: dec_strb = 4'b0001;
         4'b0010: dec_strb = 4'b0010;
         4'b0001: dec_strb = 4'b0100;
         4'b0011: dec_strb = 4'b1000;
         4'b0100: dec_strb = 4'b1111;
         4'b0101: dec_strb = 4'b0011;
         4'b0111: dec_strb = 4'b1100;
         default: dec_bad  = 1'b1;
      endcase
   end
   // transfer FSM with registered bus and local outputs; completion flags are set on entry to DONE
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state           <= IDLE;
         cnt             <= '0;
         bus.bus_ad_o    <= '0;
         bus.bus_ad_oe   <= 1'b0;
         bus.bus_rdy_o   <= 1'b0;
         bus.bus_err_o   <= 1'b0;
         bus.loc_addr_o  <= '0;
         bus.loc_wstrb_o <= '0;
         bus.loc_wdata_o <= '0;
         bus.loc_wr_o    <= 1'b0;
         bus.loc_rd_o    <= 1'b0;
         bus.overrun_o   <= 1'b0;
      end else begin
         bus.bus_rdy_o <= 1'b0;
         bus.bus_err_o <= 1'b0;
         bus.bus_ad_oe <= 1'b0;
         if (bus.bus_adrcy_i && state != IDLE) bus.overrun_o <= 1'b1;
         case (state)
            IDLE: if (bus.bus_adrcy_i) begin
               bus.loc_addr_o  <= ADDR_W'({bus.bus_ad_i[31:2], 2'b00});
               bus.loc_wstrb_o <= dec_strb;
               cnt             <= '0;
               if (dec_bad) begin
                  state         <= DONE;
                  bus.bus_rdy_o <= 1'b1;
                  bus.bus_err_o <= 1'b1;
               end else if (dec_rd) begin
                  state        <= REQ;
                  bus.loc_rd_o <= 1'b1;
               end else state <= WDATA;
            end
            WDATA: if (bus.bus_dcy_i) begin
               bus.loc_wdata_o <= bus.bus_ad_i;
               bus.loc_wr_o    <= 1'b1;
               cnt             <= '0;
               state           <= REQ;
            end
            REQ: if (bus.loc_ack_i) begin
               bus.loc_rd_o  <= 1'b0;
               bus.loc_wr_o  <= 1'b0;
               bus.bus_rdy_o <= 1'b1;
               state         <= DONE;
               if (bus.loc_rd_o) begin
                  bus.bus_ad_o  <= bus.loc_rdata_i;
                  bus.bus_ad_oe <= 1'b1;
               end
            end else if (TIMEOUT != 0 && cnt == LIM) begin
               bus.loc_rd_o  <= 1'b0;
               bus.loc_wr_o  <= 1'b0;
               bus.bus_rdy_o <= 1'b1;
               bus.bus_err_o <= 1'b1;
               state         <= DONE;
            end else cnt <= cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
